rom_read_arbiter: RTL and testbench
===================================

// Module: rom_read_arbiter
// PURPOSE
// - Two-master AXI read-channel arbiter in front of the single-ported ROM slave wrapper.
// - Shares the ROM between M0 (instruction fetch) and M1 (data read).
// - Round-robin grant, held for one full burst. Only AR/R channels; the ROM has no write path.
// - Sits between the masters' read ports and the ROM wrapper's AR/R ports.
// PARAMETERS
// - ROM_BASE  32'h0000_0000  first byte address of the ROM window (used only with ROM_ARB_DECERR_EN)
// - ROM_SIZE  32'h0001_0000  window size in bytes (64 KB = 14-bit word address)
// PORTS
// - clk            in   1               clock; all flops on posedge
// - rst_n          in   1               asynchronous reset, active low
// - ARID_M{0,1}    in   `AXI_ID_BITS    master read ID
// - ARADDR_M{0,1}  in   `AXI_ADDR_BITS  master read address
// - ARLEN_M{0,1}   in   `AXI_LEN_BITS   master burst length - 1
// - ARSIZE_M{0,1}  in   `AXI_SIZE_BITS  master beat size
// - ARBURST_M{0,1} in   2               master burst type
// - ARVALID_M{0,1} in   1               master AR valid
// - ARREADY_M{0,1} out  1               AR ready to master
// - RID_M{0,1}     out  `AXI_ID_BITS    R ID to master
// - RDATA_M{0,1}   out  `AXI_DATA_BITS  R data to master
// - RRESP_M{0,1}   out  2               R response to master
// - RLAST_M{0,1}   out  1               R last to master
// - RVALID_M{0,1}  out  1               R valid to master
// - RREADY_M{0,1}  in   1               master R ready
// - ARID_S / ARADDR_S / ARLEN_S / ARSIZE_S / ARBURST_S / ARVALID_S  out  (`AXI_IDS_BITS, ADDR, LEN, SIZE, 2, 1)  AR to ROM wrapper
// - ARREADY_S      in   1               ROM wrapper AR ready
// - RID_S / RDATA_S / RRESP_S / RLAST_S / RVALID_S  in  (`AXI_IDS_BITS, DATA, 2, 1, 1)  R from ROM wrapper
// - RREADY_S       out  1               R ready to ROM wrapper
// BEHAVIOUR
// - Reset values: all outputs 0; state = IDLE; gnt = 0; last_gnt = 1, so M0 wins the first tie.
// - FSM states: IDLE, ADDR, DATA, ERR (ERR exists only with the macro).
//   - IDLE: if any ARVALID_Mx, register gnt:
//     - only one valid: grant it;
//     - both valid: grant ~last_gnt.
//     - Move to ADDR next cycle. No outputs are asserted in IDLE.
//   - ADDR: forward the granted master's AR fields combinationally to *_S.
//     - ARID_S = {4'(gnt+1), ARID_Mg}.
//     - ARREADY_Mg = ARREADY_S; the other ARREADY_M = 0.
//     - On ARVALID_S & ARREADY_S: go to DATA.
//     - Masters hold ARVALID until the handshake (AXI rule), so no AR latch is needed.
//   - DATA: route R from the slave to the granted master only.
//     - Granted master: RVALID_Mg = RVALID_S, RID_Mg = RID_S[`AXI_ID_BITS-1:0], RDATA/RRESP/RLAST pass through.
//     - RREADY_S = RREADY_Mg.
//     - Non-granted master: all R outputs held at 0.
//     - On RVALID_S & RREADY_S & RLAST_S: go to IDLE and set last_gnt <= gnt.
// - Latency: ARVALID_Mx high in IDLE cycle N -> ARVALID_S high in cycle N+1. Zero added latency on R beats (combinational).
// - One IDLE bubble cycle between back-to-back bursts; it is the fairness point.
// - Simultaneous ARVALID from both masters in IDLE: exactly one is granted; the loser's ARREADY stays 0 until its own ADDR phase.
// - A request arriving while a burst is in DATA waits. No preemption and no interleaving.
// - Reset mid-burst: FSM returns to IDLE asynchronously and all outputs drop to 0. The ROM wrapper is reset by the same rst_n.
// - ARSIZE/ARBURST are forwarded unchanged and not checked.
// CONFIGURATION
// - Macro: ROM_ARB_DECERR_EN.
// - Defined: in ADDR, an ARADDR_Mg outside [ROM_BASE, ROM_BASE+ROM_SIZE) is not forwarded.
//   - ARVALID_S stays 0.
//   - The arbiter asserts ARREADY_Mg itself for one cycle and latches ARID/ARLEN, then enters ERR.
//   - ERR returns ARLEN+1 beats: RVALID = 1, RDATA = 0, RRESP = 2'b11 (DECERR), RLAST on beat ARLEN.
//   - Beats advance on RREADY_Mg. After the last handshake: IDLE, last_gnt <= gnt.
//   - The 4-bit beat counter is reset to 0 on entry to ERR.
// - Not defined: every address is forwarded; no ERR state, counter or range compare is synthesized.
// TESTING
// - Single M0 burst, ARADDR = 0x100, ARLEN = 3 -> ARVALID_S one cycle later with ARID_S = {4'h1, ID}; 4 beats reach M0 only; RLAST_M0 on beat 4.
// - M0 and M1 assert ARVALID in the same cycle after reset -> M0 served first, then M1 after exactly one IDLE cycle.
// - Both masters requesting continuously, 6 bursts -> grant sequence M0, M1, M0, M1, M0, M1.
// - M1 deasserts RREADY for 3 cycles mid-burst -> RREADY_S = 0 and data is held; no beat lost or duplicated; M0 outputs stay 0.
// - Assert rst_n = 0 during beat 2 of an ARLEN = 7 burst -> all outputs 0 at once; after release, a new M1 request completes normally.
// - With ROM_ARB_DECERR_EN, M1 ARADDR = 0x0002_0000, ARLEN = 1 -> ARVALID_S stays 0; 2 beats RRESP = 2'b11, RDATA = 0, RLAST on the 2nd.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - two-master round-robin AXI read arbiter in front of the ROM wrapper
// Optional ROM_ARB_DECERR_EN: reads outside the ROM window are answered locally with DECERR.
`ifndef AXI_ID_BITS
`define AXI_ID_BITS 4
`endif
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS (`AXI_ID_BITS + 4)
`endif
`ifndef AXI_ADDR_BITS
`define AXI_ADDR_BITS 32
`endif
`ifndef AXI_LEN_BITS
`define AXI_LEN_BITS 4
`endif
`ifndef AXI_SIZE_BITS
`define AXI_SIZE_BITS 3
`endif
`ifndef AXI_DATA_BITS
`define AXI_DATA_BITS 32
`endif

module rom_read_arbiter #(
  parameter logic [`AXI_ADDR_BITS-1:0] ROM_BASE = 32'h0000_0000,
  parameter logic [`AXI_ADDR_BITS-1:0] ROM_SIZE = 32'h0001_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [`AXI_ID_BITS-1:0]    ARID_M0,
  input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_M0,
  input  logic [`AXI_LEN_BITS-1:0]   ARLEN_M0,
  input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M0,
  input  logic [1:0]                 ARBURST_M0,
  input  logic                       ARVALID_M0,
  output logic                       ARREADY_M0,
  output logic [`AXI_ID_BITS-1:0]    RID_M0,
  output logic [`AXI_DATA_BITS-1:0]  RDATA_M0,
  output logic [1:0]                 RRESP_M0,
  output logic                       RLAST_M0,
  output logic                       RVALID_M0,
  input  logic                       RREADY_M0,
  input  logic [`AXI_ID_BITS-1:0]    ARID_M1,
  input  logic [`AXI_ADDR_BITS-1:0]  ARADDR_M1,
  input  logic [`AXI_LEN_BITS-1:0]   ARLEN_M1,
  input  logic [`AXI_SIZE_BITS-1:0]  ARSIZE_M1,
  input  logic [1:0]                 ARBURST_M1,
  input  logic                       ARVALID_M1,
  output logic                       ARREADY_M1,
  output logic [`AXI_ID_BITS-1:0]    RID_M1,
  output logic [`AXI_DATA_BITS-1:0]  RDATA_M1,
  output logic [1:0]                 RRESP_M1,
  output logic                       RLAST_M1,
  output logic                       RVALID_M1,
  input  logic                       RREADY_M1,
  output logic [`AXI_IDS_BITS-1:0]   ARID_S,
  output logic [`AXI_ADDR_BITS-1:0]  ARADDR_S,
  output logic [`AXI_LEN_BITS-1:0]   ARLEN_S,
  output logic [`AXI_SIZE_BITS-1:0]  ARSIZE_S,
  output logic [1:0]                 ARBURST_S,
  output logic                       ARVALID_S,
  input  logic                       ARREADY_S,
  input  logic [`AXI_IDS_BITS-1:0]   RID_S,
  input  logic [`AXI_DATA_BITS-1:0]  RDATA_S,
  input  logic [1:0]                 RRESP_S,
  input  logic                       RLAST_S,
  input  logic                       RVALID_S,
  output logic                       RREADY_S
);

`ifdef ROM_ARB_DECERR_EN
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, ERR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
`endif

  state_t state, state_nxt;
  logic   gnt, last_gnt, burst_done;
  logic   arready_g, r_valid_g, r_last_g;
  logic [`AXI_ID_BITS-1:0]   r_id_g;
  logic [`AXI_DATA_BITS-1:0] r_data_g;
  logic [1:0]                r_resp_g;

  // Granted master's request fields; masters hold them stable until the AR handshake.
  logic                      arvalid_g, rready_g;
  logic [`AXI_ID_BITS-1:0]   arid_g;
  logic [`AXI_ADDR_BITS-1:0] araddr_g;
  logic [`AXI_LEN_BITS-1:0]  arlen_g;
  assign arvalid_g = gnt ? ARVALID_M1 : ARVALID_M0;
  assign rready_g  = gnt ? RREADY_M1  : RREADY_M0;
  assign arid_g    = gnt ? ARID_M1    : ARID_M0;
  assign araddr_g  = gnt ? ARADDR_M1  : ARADDR_M0;
  assign arlen_g   = gnt ? ARLEN_M1   : ARLEN_M0;

  logic unused_rid_hi;
  assign unused_rid_hi = ^RID_S[`AXI_IDS_BITS-1:`AXI_ID_BITS];

`ifdef ROM_ARB_DECERR_EN
  logic                      in_range;
  logic [`AXI_ID_BITS-1:0]   err_id;
  logic [`AXI_LEN_BITS-1:0]  err_len, beat_cnt;
  assign in_range = (araddr_g >= ROM_BASE) && ((araddr_g - ROM_BASE) < ROM_SIZE);
`else
  localparam logic unused_window = |(ROM_BASE ^ ROM_SIZE);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    burst_done = 1'b0;
    arready_g  = 1'b0;
    r_valid_g  = 1'b0;
    r_last_g   = 1'b0;
    r_id_g     = '0;
    r_data_g   = '0;
    r_resp_g   = 2'b00;
    ARID_S     = '0;
    ARADDR_S   = '0;
    ARLEN_S    = '0;
    ARSIZE_S   = '0;
    ARBURST_S  = 2'b00;
    ARVALID_S  = 1'b0;
    RREADY_S   = 1'b0;
    case (state)
      IDLE: if (ARVALID_M0 || ARVALID_M1) state_nxt = ADDR;
      ADDR: begin
`ifdef ROM_ARB_DECERR_EN
        if (!in_range) begin
          arready_g = arvalid_g;
          if (arvalid_g) state_nxt = ERR;
        end else begin
`else
        begin
`endif
          ARID_S    = {{3'b000, gnt} + 4'd1, arid_g};
          ARADDR_S  = araddr_g;
          ARLEN_S   = arlen_g;
          ARSIZE_S  = gnt ? ARSIZE_M1 : ARSIZE_M0;
          ARBURST_S = gnt ? ARBURST_M1 : ARBURST_M0;
          ARVALID_S = arvalid_g;
          arready_g = ARREADY_S;
          if (arvalid_g && ARREADY_S) state_nxt = DATA;
        end
      end
      DATA: begin
        r_valid_g = RVALID_S;
        r_last_g  = RLAST_S;
        r_id_g    = RID_S[`AXI_ID_BITS-1:0];
        r_data_g  = RDATA_S;
        r_resp_g  = RRESP_S;
        RREADY_S  = rready_g;
        if (RVALID_S && rready_g && RLAST_S) begin
          state_nxt  = IDLE;
          burst_done = 1'b1;
        end
      end
`ifdef ROM_ARB_DECERR_EN
      ERR: begin
        r_valid_g = 1'b1;
        r_id_g    = err_id;
        r_resp_g  = 2'b11;
        r_last_g  = (beat_cnt == err_len);
        if (rready_g && r_last_g) begin
          state_nxt  = IDLE;
          burst_done = 1'b1;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // last_gnt resets to M1 so that M0 wins the first simultaneous request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      if (state == IDLE && (ARVALID_M0 || ARVALID_M1))
        gnt <= (ARVALID_M0 && ARVALID_M1) ? ~last_gnt : ARVALID_M1;
      if (burst_done) last_gnt <= gnt;
    end
  end

`ifdef ROM_ARB_DECERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_id   <= '0;
      err_len  <= '0;
      beat_cnt <= '0;
    end else if (state == ADDR && state_nxt == ERR) begin
      err_id   <= arid_g;
      err_len  <= arlen_g;
      beat_cnt <= '0;
    end else if (state == ERR && rready_g) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
`endif

  assign ARREADY_M0 = !gnt && arready_g;
  assign RVALID_M0  = !gnt && r_valid_g;
  assign RLAST_M0   = !gnt && r_last_g;
  assign RID_M0     = gnt ? '0 : r_id_g;
  assign RDATA_M0   = gnt ? '0 : r_data_g;
  assign RRESP_M0   = gnt ? 2'b00 : r_resp_g;
  assign ARREADY_M1 = gnt && arready_g;
  assign RVALID_M1  = gnt && r_valid_g;
  assign RLAST_M1   = gnt && r_last_g;
  assign RID_M1     = gnt ? r_id_g : '0;
  assign RDATA_M1   = gnt ? r_data_g : '0;
  assign RRESP_M1   = gnt ? r_resp_g : 2'b00;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - directed vector bench for rom_read_arbiter
module tb_rom_read_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1, RID_M0, RID_M1, ARLEN_S;
  logic [31:0] ARADDR_M0, ARADDR_M1, RDATA_M0, RDATA_M1, ARADDR_S, RDATA_S;
  logic [2:0]  ARSIZE_M0, ARSIZE_M1, ARSIZE_S;
  logic [1:0]  ARBURST_M0, ARBURST_M1, RRESP_M0, RRESP_M1, ARBURST_S, RRESP_S;
  logic ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
  logic RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
  logic [7:0]  ARID_S, RID_S;
  logic ARVALID_S, ARREADY_S, RLAST_S, RVALID_S, RREADY_S;

  rom_read_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0), .ARSIZE_M0(ARSIZE_M0),
    .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .RID_M0(RID_M0), .RDATA_M0(RDATA_M0), .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0),
    .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1), .ARSIZE_M1(ARSIZE_M1),
    .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .RID_M1(RID_M1), .RDATA_M1(RDATA_M1), .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S)
  );

  typedef struct packed {
    logic        arvalid_s;
    logic [7:0]  arid_s;
    logic [31:0] araddr_s;
    logic [3:0]  arlen_s;
    logic [2:0]  arsize_s;
    logic [1:0]  arburst_s;
    logic        arready_m0, arready_m1, rready_s;
    logic        rvalid_m0, rlast_m0;
    logic [1:0]  rresp_m0;
    logic [3:0]  rid_m0;
    logic [31:0] rdata_m0;
    logic        rvalid_m1, rlast_m1;
    logic [1:0]  rresp_m1;
    logic [3:0]  rid_m1;
    logic [31:0] rdata_m1;
  } out_t;

  typedef struct packed {
    logic av0, av1, ars, rvs, rls, rr0, rr1;
    logic [7:0]  rid_s;
    logic [31:0] rdata_s;
  } in_t;

  typedef struct { in_t i; out_t e; } vec_t;

  vec_t vecs[24];
  int   nv = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  function automatic out_t cur_out();
    out_t o;
    o.arvalid_s = ARVALID_S;   o.arid_s = ARID_S;        o.araddr_s = ARADDR_S;
    o.arlen_s = ARLEN_S;       o.arsize_s = ARSIZE_S;    o.arburst_s = ARBURST_S;
    o.arready_m0 = ARREADY_M0; o.arready_m1 = ARREADY_M1; o.rready_s = RREADY_S;
    o.rvalid_m0 = RVALID_M0;   o.rlast_m0 = RLAST_M0;    o.rresp_m0 = RRESP_M0;
    o.rid_m0 = RID_M0;         o.rdata_m0 = RDATA_M0;
    o.rvalid_m1 = RVALID_M1;   o.rlast_m1 = RLAST_M1;    o.rresp_m1 = RRESP_M1;
    o.rid_m1 = RID_M1;         o.rdata_m1 = RDATA_M1;
    return o;
  endfunction

  function automatic in_t mk_in(bit av0, bit av1, bit ars, bit rvs, bit rls, bit rr0, bit rr1,
                                logic [7:0] rid, logic [31:0] d);
    in_t i;
    i = {av0, av1, ars, rvs, rls, rr0, rr1, rid, d};
    return i;
  endfunction

  function automatic out_t ex_ar(bit g, bit rdy);
    out_t o = '0;
    o.arvalid_s = 1'b1;
    o.arid_s    = g ? {4'h2, ARID_M1} : {4'h1, ARID_M0};
    o.araddr_s  = g ? ARADDR_M1 : ARADDR_M0;
    o.arlen_s   = g ? ARLEN_M1 : ARLEN_M0;
    o.arsize_s  = g ? ARSIZE_M1 : ARSIZE_M0;
    o.arburst_s = g ? ARBURST_M1 : ARBURST_M0;
    if (g) o.arready_m1 = rdy; else o.arready_m0 = rdy;
    return o;
  endfunction

  function automatic out_t ex_r(bit g, bit rv, bit rl, logic [3:0] rid, logic [31:0] d, bit rr);
    out_t o = '0;
    o.rready_s = rr;
    if (g) begin
      o.rvalid_m1 = rv; o.rlast_m1 = rl; o.rresp_m1 = 2'b10; o.rid_m1 = rid; o.rdata_m1 = d;
    end else begin
      o.rvalid_m0 = rv; o.rlast_m0 = rl; o.rresp_m0 = 2'b10; o.rid_m0 = rid; o.rdata_m0 = d;
    end
    return o;
  endfunction

  task automatic add(input in_t i, input out_t e);
    vecs[nv].i = i;
    vecs[nv].e = e;
    nv++;
  endtask

  task automatic apply(input in_t i);
    ARVALID_M0 = i.av0; ARVALID_M1 = i.av1; ARREADY_S = i.ars;
    RVALID_S = i.rvs;   RLAST_S = i.rls;    RREADY_M0 = i.rr0; RREADY_M1 = i.rr1;
    RID_S = i.rid_s;    RDATA_S = i.rdata_s;
  endtask

  task automatic check_o(input string name, input int idx, input out_t got, input out_t exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
    end
  endtask

  task automatic check_v(input string name, input int idx, input logic [63:0] got,
                         input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, got, exp);
    end
  endtask

  task automatic reset_pulse();
    apply('0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_ar(input bit g, input logic [7:0] exp_id);
    bit ok = 0;
    if (g) ARVALID_M1 = 1'b1; else ARVALID_M0 = 1'b1;
    ARREADY_S = 1'b1;
    for (int c = 0; c < 8 && !ok; c++) begin
      @(negedge clk);
      if (ARVALID_S) begin
        check_v("ar_id", c, ARID_S, exp_id);
        check_v("ar_ready", c, g ? ARREADY_M1 : ARREADY_M0, 1);
        ok = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) check_v("ar_timeout", 0, 0, 1);
    ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0; ARREADY_S = 1'b0;
  endtask

  task automatic beat(input bit g, input logic [31:0] d, input bit last);
    RVALID_S = 1'b1; RDATA_S = d; RLAST_S = last; RRESP_S = 2'b10;
    RID_S = g ? {4'h2, ARID_M1} : {4'h1, ARID_M0};
    RREADY_M0 = !g; RREADY_M1 = g;
    @(negedge clk);
    check_v("beat_valid", int'(d[7:0]), g ? {RVALID_M1, RVALID_M0} : {RVALID_M0, RVALID_M1}, 2'b10);
    check_v("beat_data", int'(d[7:0]), g ? RDATA_M1 : RDATA_M0, d);
    check_v("beat_last", int'(d[7:0]), g ? RLAST_M1 : RLAST_M0, last);
    @(posedge clk);
    #1;
    RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   pfx[$];
    int   cyc[$];
    out_t zero = '0;

    ARID_M0 = 4'h5; ARADDR_M0 = 32'h0000_0100; ARLEN_M0 = 4'd3; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01;
    ARID_M1 = 4'hA; ARADDR_M1 = 32'h0000_0200; ARLEN_M1 = 4'd1; ARSIZE_M1 = 3'd3; ARBURST_M1 = 2'b10;
    RRESP_S = 2'b10;
    apply(mk_in(1, 1, 1, 1, 1, 1, 1, 8'h15, 32'hFFFF_FFFF));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_o("reset", 0, cur_out(), zero);
    @(posedge clk);
    #1 rst_n = 1'b1;

    add(mk_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0), '0);
    add(mk_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0), ex_ar(0, 0));
    add(mk_in(1, 0, 1, 0, 0, 0, 0, 8'h00, 32'h0), ex_ar(0, 1));
    add(mk_in(0, 0, 0, 1, 0, 1, 0, 8'h15, 32'hD000_0000), ex_r(0, 1, 0, 4'h5, 32'hD000_0000, 1));
    add(mk_in(0, 0, 0, 1, 0, 1, 0, 8'h15, 32'hD000_0001), ex_r(0, 1, 0, 4'h5, 32'hD000_0001, 1));
    add(mk_in(0, 0, 0, 0, 0, 1, 0, 8'h15, 32'h0),         ex_r(0, 0, 0, 4'h5, 32'h0, 1));
    add(mk_in(0, 0, 0, 1, 0, 1, 0, 8'h15, 32'hD000_0002), ex_r(0, 1, 0, 4'h5, 32'hD000_0002, 1));
    add(mk_in(0, 0, 0, 1, 1, 1, 0, 8'h15, 32'hD000_0003), ex_r(0, 1, 1, 4'h5, 32'hD000_0003, 1));
    add(mk_in(1, 1, 0, 0, 0, 0, 0, 8'h00, 32'h0), '0);
    add(mk_in(1, 1, 1, 0, 0, 0, 0, 8'h00, 32'h0), ex_ar(1, 1));
    add(mk_in(1, 0, 0, 1, 0, 1, 1, 8'h2A, 32'hE000_0000), ex_r(1, 1, 0, 4'hA, 32'hE000_0000, 1));
    for (int k = 0; k < 3; k++)
      add(mk_in(1, 0, 0, 1, 0, 1, 0, 8'h2A, 32'hE000_0001), ex_r(1, 1, 0, 4'hA, 32'hE000_0001, 0));
    add(mk_in(1, 0, 0, 1, 1, 1, 1, 8'h2A, 32'hE000_0001), ex_r(1, 1, 1, 4'hA, 32'hE000_0001, 1));
    add(mk_in(1, 0, 0, 0, 0, 0, 0, 8'h00, 32'h0), '0);
    add(mk_in(1, 0, 1, 0, 0, 0, 0, 8'h00, 32'h0), ex_ar(0, 1));
    add(mk_in(0, 0, 0, 1, 1, 1, 0, 8'h15, 32'hD000_0004), ex_r(0, 1, 1, 4'h5, 32'hD000_0004, 1));

    for (int k = 0; k < nv; k++) begin
      apply(vecs[k].i);
      @(negedge clk);
      check_o("vec", k, cur_out(), vecs[k].e);
      @(posedge clk);
      #1;
    end
    apply('0);

    // Both masters requesting back to back with single-beat bursts.
    reset_pulse();
    ARLEN_M0 = 4'd0; ARLEN_M1 = 4'd0;
    apply(mk_in(1, 1, 1, 1, 1, 1, 1, 8'h00, 32'h1234_5678));
    for (int c = 0; c < 40 && pfx.size() < 6; c++) begin
      @(negedge clk);
      if (ARVALID_S && ARREADY_S) begin
        pfx.push_back(int'(ARID_S[7:4]));
        cyc.push_back(c);
      end
      @(posedge clk);
      #1;
    end
    apply('0);
    check_v("rr_count", 0, pfx.size(), 6);
    for (int k = 0; k < pfx.size(); k++) begin
      check_v("rr_grant", k, pfx[k], (k % 2) ? 2 : 1);
      if (k > 0) check_v("rr_gap", k, cyc[k] - cyc[k-1], 3);
    end

    // Reset asserted during beat 2 of an 8-beat M0 burst.
    reset_pulse();
    ARLEN_M0 = 4'd7;
    run_ar(0, 8'h15);
    beat(0, 32'hB000_0001, 0);
    RVALID_S = 1'b1; RDATA_S = 32'hB000_0002; RID_S = 8'h15; RREADY_M0 = 1'b1; ARVALID_M1 = 1'b1;
    #2 check_v("beat2_live", 0, RVALID_M0, 1);
    rst_n = 1'b0;
    #1 check_o("reset_mid", 0, cur_out(), zero);
    apply('0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_ar(1, 8'h2A);
    beat(1, 32'hC000_0001, 0);
    beat(1, 32'hC000_0002, 1);
    @(negedge clk);
    check_o("post_reset_idle", 0, cur_out(), zero);
    @(posedge clk);
    #1;

`ifdef ROM_ARB_DECERR_EN
    reset_pulse();
    ARADDR_M1 = 32'h0002_0000; ARLEN_M1 = 4'd1;
    ARVALID_M1 = 1'b1; ARREADY_S = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_v("decerr_ar", 0, {ARVALID_S, ARREADY_M1, ARREADY_M0}, 3'b010);
    @(posedge clk);
    #1 ARVALID_M1 = 1'b0; ARREADY_S = 1'b0; RREADY_M1 = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      check_v("decerr_beat", b, {RVALID_M1, RRESP_M1, RDATA_M1, RLAST_M1, RID_M1, RVALID_M0, ARVALID_S},
              {1'b1, 2'b11, 32'h0, (b == 1), 4'hA, 1'b0, 1'b0});
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_v("decerr_done", 0, RVALID_M1, 0);
    apply('0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
